// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings, status codes and fetch-side types for the SEQ core.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 4'd4;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [2:0] {
    ST_REQ   = 3'd0,
    ST_WAIT  = 3'd1,
    ST_OUT   = 3'd2,
    ST_STOP  = 3'd3,
    ST_DRAIN = 3'd4
  } fetch_state_t;

  // Fields collected byte by byte while an instruction is being read.
  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  len;
    logic        has_regs;
    logic        has_valc;
    logic [63:0] valc;
  } fetch_asm_t;

  localparam fetch_asm_t ASM_CLEAR = '{
    icode: 4'h0, ifun: 4'h0, ra: RNONE, rb: RNONE,
    len: 4'd0, has_regs: 1'b0, has_valc: 1'b0, valc: 64'd0
  };

  function automatic logic [3:0] instr_len(input logic [3:0] code);
    case (code)
      I_HALT, I_NOP, I_RET:                  return 4'd1;
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:      return 4'd2;
      I_JXX, I_CALL:                         return 4'd9;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:          return 4'd10;
      default:                               return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/ifetch_len_decode.sv
// Combinational icode classifier: instruction length and which optional bytes follow.
module ifetch_len_decode
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  output logic [3:0] length,
  output logic       has_regs,
  output logic       has_valc,
  output logic       invalid
);

  always_comb begin
    length   = instr_len(icode);
    invalid  = (length == 4'd0);
    has_regs = (length == 4'd2) || (length == 4'd10);
    has_valc = (length == 4'd9) || (length == 4'd10);
  end

endmodule

// File: rtl/ifetch_sequencer.sv
// Multi-cycle Y86-64 fetch: one byte read per request, assembles the instruction and
// hands it to decode over valid/ready, freezing on halt, bad address or bad icode.
module ifetch_sequencer
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter logic [63:0] MEM_LAST = 64'd127
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_rd,
  output logic [63:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_valid,
  input  logic        pc_load,
  input  logic [63:0] pc_new,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic [63:0] pc_out,
  output logic [2:0]  stat
);

  fetch_state_t state, state_nxt;

  logic [63:0] pc, pc_nxt;
  logic [63:0] redirect_pc, redirect_nxt;
  logic [63:0] fetch_addr;
  logic [3:0]  idx, idx_nxt;
  logic [3:0]  cur_len;
  logic [3:0]  vc_k;
  logic        addr_bad;
  logic        capture;
  logic        restart;
  logic        load_out;
  logic [2:0]  out_stat;

  fetch_asm_t  asm_q, asm_nxt;

  logic [3:0]  d_len;
  logic        d_regs;
  logic        d_valc;
  logic        d_inv;

  // Only meaningful for byte 0; later bytes use the length latched then.
  ifetch_len_decode u_len_decode (
    .icode    (mem_rdata[7:4]),
    .length   (d_len),
    .has_regs (d_regs),
    .has_valc (d_valc),
    .invalid  (d_inv)
  );

  assign fetch_addr = pc + {60'd0, idx};
  assign addr_bad   = (fetch_addr > MEM_LAST);
  assign cur_len    = (idx == 4'd0) ? d_len : asm_q.len;
  assign out_valid  = (state == ST_OUT) || (state == ST_STOP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_REQ;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    idx_nxt      = idx;
    redirect_nxt = redirect_pc;
    mem_rd       = 1'b0;
    mem_addr     = 64'd0;
    capture      = 1'b0;
    restart      = 1'b0;
    load_out     = 1'b0;
    out_stat     = S_AOK;

    case (state)
      ST_REQ: begin
        if (pc_load) begin
          pc_nxt  = pc_new;
          idx_nxt = 4'd0;
          restart = 1'b1;
        end else if (addr_bad) begin
          state_nxt = ST_STOP;
          load_out  = 1'b1;
          out_stat  = S_ADR;
        end else begin
          mem_rd    = 1'b1;
          mem_addr  = fetch_addr;
          state_nxt = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (pc_load) begin
          // A byte landing in the same cycle as the redirect is simply dropped.
          if (mem_valid) begin
            pc_nxt    = pc_new;
            idx_nxt   = 4'd0;
            restart   = 1'b1;
            state_nxt = ST_REQ;
          end else begin
            redirect_nxt = pc_new;
            state_nxt    = ST_DRAIN;
          end
        end else if (mem_valid) begin
          capture = 1'b1;
          if ((idx == 4'd0) && d_inv) begin
            state_nxt = ST_OUT;
            load_out  = 1'b1;
            out_stat  = S_INS;
          end else if (idx == cur_len - 4'd1) begin
            state_nxt = ST_OUT;
            load_out  = 1'b1;
            out_stat  = ((idx == 4'd0) && (mem_rdata[7:4] == I_HALT)) ? S_HLT : S_AOK;
          end else begin
            idx_nxt   = idx + 4'd1;
            state_nxt = ST_REQ;
          end
        end
      end

      ST_OUT: begin
        if (out_ready) begin
          if (stat != S_AOK) begin
            state_nxt = ST_STOP;
          end else begin
            pc_nxt    = pc_load ? pc_new : valP;
            idx_nxt   = 4'd0;
            restart   = 1'b1;
            state_nxt = ST_REQ;
          end
        end
      end

      ST_DRAIN: begin
        if (pc_load) begin
          redirect_nxt = pc_new;
        end
        if (mem_valid) begin
          pc_nxt    = pc_load ? pc_new : redirect_pc;
          idx_nxt   = 4'd0;
          restart   = 1'b1;
          state_nxt = ST_REQ;
        end
      end

      default: begin
        state_nxt = state;
      end
    endcase

    // No read may escape while reset is held, whatever state we are leaving.
    if (reset) begin
      mem_rd   = 1'b0;
      mem_addr = 64'd0;
    end
  end

  always_comb begin
    asm_nxt = asm_q;
    vc_k    = idx - (asm_q.has_regs ? 4'd2 : 4'd1);
    if (restart) begin
      asm_nxt = ASM_CLEAR;
    end else if (capture) begin
      if (idx == 4'd0) begin
        asm_nxt.icode    = mem_rdata[7:4];
        asm_nxt.ifun     = mem_rdata[3:0];
        asm_nxt.len      = d_len;
        asm_nxt.has_regs = d_regs;
        asm_nxt.has_valc = d_valc;
      end else if (asm_q.has_regs && (idx == 4'd1)) begin
        asm_nxt.ra = mem_rdata[7:4];
        asm_nxt.rb = mem_rdata[3:0];
      end else if (asm_q.has_valc) begin
        for (int k = 0; k < 8; k++) begin
          if (vc_k == 4'(k)) begin
            asm_nxt.valc[8*k +: 8] = mem_rdata;
          end
        end
      end
    end
  end

  // Presented fields change only when an instruction enters OUT or STOP.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      idx         <= 4'd0;
      redirect_pc <= 64'd0;
      asm_q       <= ASM_CLEAR;
      icode       <= 4'h0;
      ifun        <= 4'h0;
      rA          <= RNONE;
      rB          <= RNONE;
      valC        <= 64'd0;
      valP        <= 64'd0;
      pc_out      <= 64'd0;
      stat        <= S_AOK;
    end else begin
      pc          <= pc_nxt;
      idx         <= idx_nxt;
      redirect_pc <= redirect_nxt;
      asm_q       <= asm_nxt;
      if (load_out) begin
        icode  <= asm_nxt.icode;
        ifun   <= asm_nxt.ifun;
        rA     <= asm_nxt.ra;
        rB     <= asm_nxt.rb;
        valC   <= asm_nxt.valc;
        valP   <= pc + {60'd0, asm_nxt.len};
        pc_out <= pc;
        stat   <= out_stat;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_sequencer.sv
// Scoreboard bench for ifetch_sequencer: byte memory model with programmable latency.
module tb_ifetch_sequencer;
  import y86_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_rd;
  logic [63:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_valid = 1'b0;
  logic        pc_load = 1'b0;
  logic [63:0] pc_new = 64'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP, pc_out;
  logic [2:0]  stat;

  always #5 clk = ~clk;

  ifetch_sequencer #(.RESET_PC(64'd0), .MEM_LAST(64'd127)) dut (
    .clk(clk), .reset(reset), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .pc_load(pc_load), .pc_new(pc_new),
    .out_valid(out_valid), .out_ready(out_ready), .icode(icode), .ifun(ifun),
    .rA(rA), .rB(rB), .valC(valC), .valP(valP), .pc_out(pc_out), .stat(stat)
  );

  typedef struct packed {
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp, pc;
    logic [2:0]  st;
  } instr_t;

  instr_t      exp_q[$];
  logic [63:0] addr_q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  logic [7:0]  mem [0:127];
  int          mem_lat = 1;
  int          pend_cnt = 0;
  logic [63:0] pend_addr = 64'd0;

  function automatic instr_t mk(input logic [3:0] ic, input logic [3:0] fn,
                                input logic [3:0] ra, input logic [3:0] rb,
                                input logic [63:0] vc, input logic [63:0] vp,
                                input logic [63:0] pc, input logic [2:0] st);
    mk = '{icode: ic, ifun: fn, ra: ra, rb: rb, valc: vc, valp: vp, pc: pc, st: st};
  endfunction

  // Memory model: exactly one response per read, mem_lat cycles later.
  always @(posedge clk) begin
    mem_valid <= 1'b0;
    if (pend_cnt > 0) begin
      if (pend_cnt == 1) begin
        mem_valid <= 1'b1;
        mem_rdata <= mem[pend_addr[6:0]];
      end
      pend_cnt <= pend_cnt - 1;
    end
    if (mem_rd) begin
      if (mem_lat == 1) begin
        mem_valid <= 1'b1;
        mem_rdata <= mem[mem_addr[6:0]];
      end else begin
        pend_cnt  <= mem_lat - 1;
        pend_addr <= mem_addr;
      end
    end
  end

  logic [63:0] mon_addr;
  always @(negedge clk) begin
    if (!reset && mem_rd) begin
      n_checks++;
      if (addr_q.size() == 0) begin
        n_fail++;
        $display("FAIL mem_read: unexpected read at addr %0d, none expected", mem_addr);
      end else begin
        mon_addr = addr_q.pop_front();
        if (mem_addr !== mon_addr) begin
          n_fail++;
          $display("FAIL mem_read: got addr %0d want %0d", mem_addr, mon_addr);
        end
      end
    end
  end

  logic   ov_prev = 1'b0;
  instr_t mon_exp, mon_got;
  always @(negedge clk) begin
    if (reset) begin
      ov_prev = 1'b0;
    end else begin
      if (out_valid && !ov_prev) begin
        n_checks++;
        mon_got = {icode, ifun, rA, rB, valC, valP, pc_out, stat};
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL instr: unexpected instruction %h", mon_got);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_got !== mon_exp) begin
            n_fail++;
            $display("FAIL instr: got %h want %h", mon_got, mon_exp);
          end
        end
      end
      ov_prev = out_valid;
    end
  end

  task automatic hold_reset();
    reset = 1'b1;
    pc_load = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Leaves reset with a one-cycle redirect to the start address.
  task automatic start(input logic [63:0] pc0);
    reset = 1'b0;
    pc_load = 1'b1;
    pc_new = pc0;
    @(posedge clk); #1;
    pc_load = 1'b0;
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < max; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && addr_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({mem_rd, out_valid, mem_addr} !== {1'b0, 1'b0, 64'd0}) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rd=%b ov=%b addr=%0d want 0/0/0", mem_rd, out_valid, mem_addr);
    end
    n_checks++;
    if ({icode, ifun, rA, rB} !== 16'h00FF) begin
      n_fail++;
      $display("FAIL reset_fields: got %h want 00ff", {icode, ifun, rA, rB});
    end
    n_checks++;
    if ({valC, valP, pc_out} !== 192'd0) begin
      n_fail++;
      $display("FAIL reset_values: got valC=%0d valP=%0d pc_out=%0d want 0", valC, valP, pc_out);
    end
    n_checks++;
    if (stat !== S_AOK) begin
      n_fail++;
      $display("FAIL reset_stat: got %0d want 1", stat);
    end
  endtask

  task automatic test_nop_halt();
    int cnt;
    bit ok;
    hold_reset();
    mem[0] = 8'h10;
    mem[1] = 8'h00;
    addr_q.push_back(64'd0);
    addr_q.push_back(64'd1);
    exp_q.push_back(mk(4'h1, 4'h0, RNONE, RNONE, 64'd0, 64'd1, 64'd0, S_AOK));
    exp_q.push_back(mk(4'h0, 4'h0, RNONE, RNONE, 64'd0, 64'd2, 64'd1, S_HLT));
    out_ready = 1'b1;
    start(64'd0);
    cnt = 0;
    while (!out_valid && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    n_checks++;
    if (cnt != 2) begin
      n_fail++;
      $display("FAIL nop_latency: got %0d cycles want 2", cnt);
    end
    wait_idle(100, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL nop_halt_done: got pending exp=%0d addr=%0d want 0", exp_q.size(), addr_q.size());
    end
    pc_load = 1'b1;
    pc_new = 64'd5;
    repeat (2) @(posedge clk);
    #1;
    pc_load = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({out_valid, stat, pc_out, icode} !== {1'b1, S_HLT, 64'd1, 4'h0}) begin
      n_fail++;
      $display("FAIL halt_stop: got ov=%b stat=%0d pc_out=%0d icode=%0d want 1/2/1/0",
               out_valid, stat, pc_out, icode);
    end
  endtask

  task automatic test_irmovq();
    bit ok;
    logic [7:0] prog [0:9];
    prog = '{8'h30, 8'hF2, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    hold_reset();
    for (int i = 0; i < 10; i++) mem[3 + i] = prog[i];
    for (int a = 3; a <= 13; a++) addr_q.push_back(64'(a));
    exp_q.push_back(mk(4'h3, 4'h0, RNONE, 4'h2, 64'd5, 64'd13, 64'd3, S_AOK));
    exp_q.push_back(mk(4'h0, 4'h0, RNONE, RNONE, 64'd0, 64'd14, 64'd13, S_HLT));
    out_ready = 1'b1;
    start(64'd3);
    wait_idle(200, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL irmovq_done: got pending exp=%0d addr=%0d want 0", exp_q.size(), addr_q.size());
    end
  endtask

  task automatic test_stall_redirect();
    bit ok;
    int cnt;
    hold_reset();
    mem[41] = 8'h73;
    mem[42] = 8'h35;
    mem[53] = 8'h10;
    for (int a = 41; a <= 49; a++) addr_q.push_back(64'(a));
    addr_q.push_back(64'd53);
    addr_q.push_back(64'd54);
    exp_q.push_back(mk(4'h7, 4'h3, RNONE, RNONE, 64'd53, 64'd50, 64'd41, S_AOK));
    exp_q.push_back(mk(4'h1, 4'h0, RNONE, RNONE, 64'd0, 64'd54, 64'd53, S_AOK));
    exp_q.push_back(mk(4'h0, 4'h0, RNONE, RNONE, 64'd0, 64'd55, 64'd54, S_HLT));
    start(64'd41);
    cnt = 0;
    while (!out_valid && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    n_checks++;
    if (!out_valid) begin
      n_fail++;
      $display("FAIL jxx_present: got out_valid=0 after %0d cycles want 1", cnt);
    end
    for (int s = 0; s < 5; s++) begin
      n_checks++;
      if ({out_valid, valC, valP, rA, rB, pc_out} !== {1'b1, 64'd53, 64'd50, RNONE, RNONE, 64'd41}) begin
        n_fail++;
        $display("FAIL jxx_stall%0d: got ov=%b valC=%0d valP=%0d rA=%h rB=%h pc=%0d want 1/53/50/f/f/41",
                 s, out_valid, valC, valP, rA, rB, pc_out);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    pc_load = 1'b1;
    pc_new = 64'd53;
    @(posedge clk); #1;
    pc_load = 1'b0;
    wait_idle(200, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL redirect_done: got pending exp=%0d addr=%0d want 0", exp_q.size(), addr_q.size());
    end
  endtask

  task automatic test_invalid();
    bit ok;
    hold_reset();
    mem[0] = 8'hC0;
    addr_q.push_back(64'd0);
    exp_q.push_back(mk(4'hC, 4'h0, RNONE, RNONE, 64'd0, 64'd0, 64'd0, S_INS));
    out_ready = 1'b1;
    start(64'd0);
    wait_idle(50, ok);
    repeat (8) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (!ok || {out_valid, stat} !== {1'b1, S_INS}) begin
      n_fail++;
      $display("FAIL invalid_stop: got ok=%b ov=%b stat=%0d want 1/1/4", ok, out_valid, stat);
    end
  endtask

  task automatic test_adr();
    bit ok;
    hold_reset();
    mem[120] = 8'h30;
    mem[121] = 8'hF2;
    for (int i = 0; i < 6; i++) mem[122 + i] = 8'(8'h11 * (i + 1));
    for (int a = 120; a <= 127; a++) addr_q.push_back(64'(a));
    exp_q.push_back(mk(4'h3, 4'h0, RNONE, 4'h2, 64'h0000_6655_4433_2211, 64'd130, 64'd120, S_ADR));
    out_ready = 1'b1;
    start(64'd120);
    wait_idle(100, ok);
    repeat (8) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (!ok || {out_valid, stat} !== {1'b1, S_ADR}) begin
      n_fail++;
      $display("FAIL adr_stop: got ok=%b ov=%b stat=%0d want 1/1/3", ok, out_valid, stat);
    end
  endtask

  task automatic test_drain();
    bit ok;
    bit seen;
    hold_reset();
    mem_lat = 3;
    mem[60] = 8'h60;
    mem[61] = 8'h12;
    mem[69] = 8'h10;
    addr_q.push_back(64'd60);
    addr_q.push_back(64'd61);
    addr_q.push_back(64'd69);
    addr_q.push_back(64'd70);
    exp_q.push_back(mk(4'h1, 4'h0, RNONE, RNONE, 64'd0, 64'd70, 64'd69, S_AOK));
    exp_q.push_back(mk(4'h0, 4'h0, RNONE, RNONE, 64'd0, 64'd71, 64'd70, S_HLT));
    out_ready = 1'b1;
    start(64'd60);
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (mem_rd && mem_addr == 64'd61) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL drain_byte1: got no read at 61 want one");
    end
    @(posedge clk); #1;
    pc_load = 1'b1;
    pc_new = 64'd69;
    @(posedge clk); #1;
    pc_load = 1'b0;
    wait_idle(200, ok);
    n_checks++;
    if (!ok || {out_valid, stat, pc_out} !== {1'b1, S_HLT, 64'd70}) begin
      n_fail++;
      $display("FAIL drain_done: got ok=%b ov=%b stat=%0d pc_out=%0d want 1/1/2/70",
               ok, out_valid, stat, pc_out);
    end
    mem_lat = 1;
  endtask

  initial begin
    test_reset();
    test_nop_halt();
    test_irmovq();
    test_stall_redirect();
    test_invalid();
    test_adr();
    test_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/ifetch_sequencer.md
Name: ifetch_sequencer

Overview:
- Multi-cycle instruction fetch controller for the Y86-64 SEQ core.
- Owns the PC register and reads the byte-wide instruction memory one byte per request.
- Assembles icode/ifun/rA/rB/valC/valP and presents them to decode over a valid/ready handshake.
- Detects halt, invalid instruction and memory error, and freezes on any of them.

Parameters:
- RESET_PC, 64'd0, PC loaded on reset.
- MEM_LAST, 64'd127, highest legal instruction byte address.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_rd  out  1  one-cycle byte read strobe.
- mem_addr  out  64  byte address, valid when mem_rd=1.
- mem_rdata  in  8  returned byte, qualified by mem_valid.
- mem_valid  in  1  read data valid; at least 1 cycle after mem_rd; exactly one per mem_rd.
- pc_load  in  1  redirect request (jump, call, ret target from later stages).
- pc_new  in  64  redirect target.
- out_valid  out  1  fetched instruction available.
- out_ready  in  1  decode accepts the instruction.
- icode, ifun, rA, rB  out  4 each  decoded fields; rA/rB=4'hF when the instruction has no register byte.
- valC  out  64  little-endian constant; 0 when absent.
- valP  out  64  PC + instruction length.
- pc_out  out  64  address of the presented instruction.
- stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS.

Behaviour:
- Reset values:
  - PC=RESET_PC, state=REQ.
  - mem_rd=0, mem_addr=0, out_valid=0.
  - icode=ifun=0, rA=rB=4'hF, valC=0, valP=0, pc_out=0, stat=1.
- Instruction length by icode:
  - 1 byte: 0 halt, 1 nop, 9 ret.
  - 2 bytes: 2 rrmov/cmov, 6 opq, A push, B pop.
  - 9 bytes: 7 jxx, 8 call.
  - 10 bytes: 3 irmov, 4 rmmov, 5 mrmov.
  - icode >= 4'hC is invalid.
- Byte layout:
  - Byte 0 = {icode, ifun}.
  - For 2- and 10-byte instructions, byte 1 = {rA, rB}.
  - valC is byte k at bits [8k+7:8k], where k counts from the first valC byte.
  - valC starts at byte 2 for 10-byte instructions and at byte 1 for 9-byte instructions.
- Byte counter: idx 0..9; address = PC + idx, 64-bit wrap.
- State machine:
  - REQ:
    - If PC+idx > MEM_LAST: go to STOP with stat=3. No read is issued.
    - Otherwise: drive mem_rd=1, mem_addr=PC+idx, then go to WAIT.
  - WAIT:
    - Hold until mem_valid, then capture the byte.
    - If idx=0, decode the length.
    - If idx=0 and icode is invalid: stat=4, go to OUT.
    - If idx=length-1: go to OUT. Otherwise idx++ and go to REQ.
  - OUT:
    - out_valid=1, all outputs held stable.
    - On out_valid & out_ready:
      - stat 2/3/4: go to STOP.
      - Otherwise: PC <= pc_load ? pc_new : valP, idx=0, go to REQ.
  - STOP:
    - out_valid=1 with the frozen instruction and stat.
    - No further reads. pc_load is ignored. Only reset exits.
  - DRAIN:
    - Entered on a redirect during WAIT.
    - Discard the next mem_valid byte, then go to REQ at the redirect target.
- icode=0: stat=2 (HLT), presented once.
- ADR mid-instruction: the partially assembled fields are presented with stat=3.
- Redirect handling:
  - pc_load in REQ: PC <= pc_new, idx=0, no read that cycle.
  - pc_load in WAIT: latch pc_new, go to DRAIN.
  - pc_load coincident with acceptance in OUT: pc_new wins over valP.
- Output timing:
  - Fields update only on transition into OUT.
  - Latency from first mem_rd to out_valid is 2*length cycles at minimum with 1-cycle memory.
- Reset mid-operation: abandons the fetch. A pending mem_valid after reset is ignored, because REQ re-issues only after reset deasserts.
- Spurious mem_valid outside WAIT/DRAIN is ignored.

Decomposition:
- Shared package y86_pkg:
  - icode constants: I_HALT..I_POPQ.
  - stat constants: S_AOK=1, S_HLT=2, S_ADR=3, S_INS=4.
  - RNONE=4'hF.
  - Function instr_len(icode) returning 4 bits, 0 for invalid.
- One sub-module, ifetch_len_decode: combinational icode -> {length, has_regs, has_valC, invalid}; reused by the pipelined core.

Test Plan:
- nop at 0, then halt at 1, memory with 1-cycle latency:
  - First fetch: icode=1, valP=1, stat=1.
  - Second fetch: icode=0, stat=2.
  - STOP reached, no further mem_rd.
- irmovq bytes 30 F2 05 00 00 00 00 00 00 00 at PC=3:
  - 10 reads at addresses 3..12.
  - rA=F, rB=2, valC=5, valP=13.
- jxx 73 35 00.. at PC=41, out_ready held low for 5 cycles:
  - Outputs stable while stalled: valC=53, valP=50, rA=rB=F.
  - pc_load=1, pc_new=53 at acceptance -> next mem_addr=53.
- Byte C0 at PC=0 -> one read, stat=4, out_valid, then STOP.
- MEM_LAST=127, irmovq at PC=120 -> reads 120..127 only, stat=3, no read at 128.
- pc_load (pc_new=69) asserted while waiting on byte 1 of an opq:
  - In-flight byte is discarded.
  - Next mem_addr=69, next instruction is fetched from 69.
